// File: rtl/mos6502s_stack_sequencer.sv
// Stack transfer sequencer: walks 1-3 byte pushes and pulls through the bus,
// stepping the stack pointer one byte per accepted bus cycle.
module mos6502s_stack_sequencer #(
  parameter bit WRAP_FLAG_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op_push,
  input  logic [1:0]  op_len,
  input  logic [23:0] push_data,
  input  logic [7:0]  sp,
  input  logic [15:0] sp_addr,
  input  logic [15:0] sp_addr_p1,
  output logic        sp_inc,
  output logic        sp_dec,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic        mem_ready,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [23:0] pull_data,
  output logic        stk_wrap
);

  typedef enum logic [2:0] {IDLE, PUSH, PULL, PULL_TAIL, DONE} state_t;

  state_t      state;
  logic [1:0]  len_q;
  logic [1:0]  cnt;
  logic [23:0] data_q;
  logic [23:0] pull_buf;
  logic [23:0] pull_buf_next;
  logic        cap_pending;
  logic [1:0]  cap_idx;
  logic [1:0]  push_sel;
  logic [7:0]  push_byte;
  logic        last_byte;

  // Pushes go out most-significant byte first; pulled bytes land lowest first.
  always_comb begin
    push_sel      = len_q - 2'd1 - cnt;
    push_byte     = data_q[{push_sel, 3'b000} +: 8];
    last_byte     = (cnt == (len_q - 2'd1));
    pull_buf_next = pull_buf;
    if (cap_pending) pull_buf_next[{cap_idx, 3'b000} +: 8] = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      len_q       <= 2'd0;
      cnt         <= 2'd0;
      data_q      <= 24'd0;
      pull_buf    <= 24'd0;
      pull_data   <= 24'd0;
      cap_pending <= 1'b0;
      cap_idx     <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          cap_pending <= 1'b0;
          if (start && (op_len != 2'd0)) begin
            len_q  <= op_len;
            data_q <= push_data;
            cnt    <= 2'd0;
            if (op_push) begin
              state <= PUSH;
            end else begin
              state    <= PULL;
              pull_buf <= 24'd0;
            end
          end
        end
        PUSH: begin
          if (mem_ready) begin
            if (last_byte) state <= DONE;
            else           cnt   <= cnt + 2'd1;
          end
        end
        PULL: begin
          // Read data trails its accepted request by one cycle, so each
          // capture overlaps the next request.
          pull_buf    <= pull_buf_next;
          cap_pending <= mem_ready;
          if (mem_ready) begin
            cap_idx <= cnt;
            cnt     <= cnt + 2'd1;
            if (last_byte) state <= PULL_TAIL;
          end
        end
        PULL_TAIL: begin
          pull_buf    <= pull_buf_next;
          pull_data   <= pull_buf_next;
          cap_pending <= 1'b0;
          state       <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are squelched in a reset cycle so an aborted transfer issues nothing more.
  assign mem_we    = (state == PUSH) && !rst;
  assign mem_re    = (state == PULL) && !rst;
  assign sp_dec    = mem_we && mem_ready;
  assign sp_inc    = mem_re && mem_ready;
  assign mem_addr  = mem_we ? sp_addr : (mem_re ? sp_addr_p1 : 16'h0000);
  assign mem_wdata = mem_we ? push_byte : 8'h00;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign stk_wrap  = WRAP_FLAG_EN &&
                     ((sp_dec && (sp == 8'h00)) || (sp_inc && (sp == 8'hFF)));

endmodule
